// File: rtl/ysyx_23060201_gpr_rsp_if.sv
// Operand-read request, response slot and writeback port bundle for the GPR responder.
// The master modport is the decode/writeback side; the slave modport is the register file.
interface ysyx_23060201_gpr_rsp_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        gpr_ren;
    logic [4:0]        raddr1;
    logic [4:0]        raddr2;
    logic              rsv_valid;
    logic [4:0]        rsv_rd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] a0;

    modport master (
        output req_valid, gpr_ren, raddr1, raddr2, rsv_valid, rsv_rd,
        output rsp_ready, wb_valid, wb_rd, wb_data,
        input  req_ready, rsp_valid, rdata1, rdata2, a0
    );

    modport slave (
        input  req_valid, gpr_ren, raddr1, raddr2, rsv_valid, rsv_rd,
        input  rsp_ready, wb_valid, wb_rd, wb_data,
        output req_ready, rsp_valid, rdata1, rdata2, a0
    );
endinterface

// File: rtl/ysyx_23060201_gpr_rsp.sv
// RV32 register file answering operand-read requests through a one-entry response slot,
// with a per-register busy scoreboard that stalls RAW/WAW hazards and bypasses writeback data.
module ysyx_23060201_gpr_rsp #(
    parameter int NR_REGS = 32,
    parameter int DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_23060201_gpr_rsp_if.slave   bus
);
    localparam int        AW        = $clog2(NR_REGS);
    localparam logic [5:0] REG_LIMIT = 6'(NR_REGS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e state;
    slot_e state_nxt;

    logic [DATA_W-1:0]  rf [NR_REGS];
    logic [NR_REGS-1:0] busy;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  rdata2;

    logic [AW-1:0]      idx1;
    logic [AW-1:0]      idx2;
    logic [AW-1:0]      idx_d;
    logic [AW-1:0]      idx_wb;
    logic               ok1;
    logic               ok2;
    logic               ok_d;
    logic               ok_wb;
    logic               byp1;
    logic               byp2;
    logic               byp_d;
    logic               hz_s1;
    logic               hz_s2;
    logic               hz_d;
    logic               req_ready;
    logic               fire;
    logic               wb_write;
    logic               rsv_set;
    logic [DATA_W-1:0]  op1;
    logic [DATA_W-1:0]  op2;

    // x0 and indices beyond the implemented register count behave as non-existent registers
    function automatic logic real_reg(input logic [4:0] idx);
        return (idx != 5'd0) && ({1'b0, idx} < REG_LIMIT);
    endfunction

    assign idx1   = bus.raddr1[AW-1:0];
    assign idx2   = bus.raddr2[AW-1:0];
    assign idx_d  = bus.rsv_rd[AW-1:0];
    assign idx_wb = bus.wb_rd[AW-1:0];

    assign ok1    = real_reg(bus.raddr1);
    assign ok2    = real_reg(bus.raddr2);
    assign ok_d   = real_reg(bus.rsv_rd);
    assign ok_wb  = real_reg(bus.wb_rd);

    assign byp1   = bus.wb_valid && (bus.wb_rd == bus.raddr1);
    assign byp2   = bus.wb_valid && (bus.wb_rd == bus.raddr2);
    assign byp_d  = bus.wb_valid && (bus.wb_rd == bus.rsv_rd);

    // A writeback landing this cycle releases the hazard immediately, so no bubble follows it
    assign hz_s1  = bus.gpr_ren[0] && ok1 && busy[idx1] && !byp1;
    assign hz_s2  = bus.gpr_ren[1] && ok2 && busy[idx2] && !byp2;
    assign hz_d   = bus.rsv_valid && ok_d && busy[idx_d] && !byp_d;

    assign req_ready = ((state == EMPTY) || bus.rsp_ready) && !hz_s1 && !hz_s2 && !hz_d;
    assign fire      = bus.req_valid && req_ready;
    assign wb_write  = bus.wb_valid && ok_wb;
    assign rsv_set   = fire && bus.rsv_valid && ok_d;

    always_comb begin
        op1 = '0;
        op2 = '0;
        if (bus.gpr_ren[0] && ok1) begin
            op1 = byp1 ? bus.wb_data : rf[idx1];
        end
        if (bus.gpr_ren[1] && ok2) begin
            op2 = byp2 ? bus.wb_data : rf[idx2];
        end
    end

    // Register array and scoreboard; the reservation is applied after the clear so set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REGS; i++) begin
                rf[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wb_write) begin
                rf[idx_wb]   <= bus.wb_data;
                busy[idx_wb] <= 1'b0;
            end
            if (rsv_set) begin
                busy[idx_d] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (fire) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (fire) begin
                    state_nxt = FULL;
                end else if (bus.rsp_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Operands only move on fire, which keeps them frozen while the consumer back-pressures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (fire) begin
            rdata1 <= op1;
            rdata2 <= op2;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state == FULL);
    assign bus.rdata1    = rdata1;
    assign bus.rdata2    = rdata2;
    assign bus.a0        = rf[10];

endmodule

// File: tb/tb_ysyx_23060201_gpr_rsp.sv
// Scoreboard bench: stimulus predicts each response from an array model and queues it;
// a negedge monitor compares whatever the response slot presents against the queue head.
module tb_ysyx_23060201_gpr_rsp;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ysyx_23060201_gpr_rsp_if #(.DATA_W(DW)) bus ();

    ysyx_23060201_gpr_rsp #(.NR_REGS(32), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] m_rf   [32];
    bit          m_busy [32];
    bit          m_full;
    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_full = 1'b0;
        exp_q.delete();
    endfunction

    function automatic logic [31:0] m_read(input logic en, input logic [4:0] idx);
        if (!en || idx == 5'd0) return '0;
        if (bus.wb_valid && bus.wb_rd == idx) return bus.wb_data;
        return m_rf[idx];
    endfunction

    function automatic bit m_blocked(input logic en, input logic [4:0] idx);
        return en && idx != 5'd0 && m_busy[idx] && !(bus.wb_valid && bus.wb_rd == idx);
    endfunction

    function automatic bit m_ready();
        return (!m_full || bus.rsp_ready)
            && !m_blocked(bus.gpr_ren[0], bus.raddr1)
            && !m_blocked(bus.gpr_ren[1], bus.raddr2)
            && !m_blocked(bus.rsv_valid, bus.rsv_rd);
    endfunction

    // Called just after a rising edge: drive one cycle, predict, then advance the model at the edge
    task automatic apply_stimulus(
        input logic        rv,
        input logic [1:0]  ren,
        input logic [4:0]  a1,
        input logic [4:0]  a2,
        input logic        rsvv,
        input logic [4:0]  rd,
        input logic        rr,
        input logic        wbv,
        input logic [4:0]  wrd,
        input logic [31:0] wdata,
        output bit         fired
    );
        bit   exp_ready;
        rsp_t e;
        bus.req_valid = rv;
        bus.gpr_ren   = ren;
        bus.raddr1    = a1;
        bus.raddr2    = a2;
        bus.rsv_valid = rsvv;
        bus.rsv_rd    = rd;
        bus.rsp_ready = rr;
        bus.wb_valid  = wbv;
        bus.wb_rd     = wrd;
        bus.wb_data   = wdata;
        #1;
        exp_ready = m_ready();
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("a0", bus.a0, m_rf[10]);
        fired = rv && exp_ready;
        e.d1  = m_read(ren[0], a1);
        e.d2  = m_read(ren[1], a2);
        @(posedge clk);
        if (fired) exp_q.push_back(e);
        if (wbv && wrd != 5'd0) begin
            m_rf[wrd]   = wdata;
            m_busy[wrd] = 1'b0;
        end
        if (fired && rsvv && rd != 5'd0) m_busy[rd] = 1'b1;
        if (fired) m_full = 1'b1;
        else if (rr) m_full = 1'b0;
        #1;
    endtask

    task automatic idle(input logic rr);
        bit f;
        apply_stimulus(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, rr, 1'b0, 5'd0, 32'h0, f);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_rdata1"}, bus.rdata1, 32'h0);
        check({tag, "_rdata2"}, bus.rdata2, 32'h0);
        check({tag, "_a0"}, bus.a0, 32'h0);
    endtask

    // Asynchronous reset dropped mid-cycle, checked before any clock edge can occur
    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.rsv_valid = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() != 0) begin
                check("rsp_valid", 32'(bus.rsp_valid), 32'h1);
                check("rdata1", bus.rdata1, exp_q[0].d1);
                check("rdata2", bus.rdata2, exp_q[0].d2);
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_idle", 32'(bus.rsp_valid), 32'h0);
            end
        end
    end

    initial begin
        bit          f;
        logic [4:0]  wrd;
        logic [4:0]  start;
        bus.req_valid = 1'b0;
        bus.gpr_ren   = 2'b00;
        bus.raddr1    = '0;
        bus.raddr2    = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_rd    = '0;
        bus.rsp_ready = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("power_on");
        rst_n = 1'b1;

        // x0 and an unwritten register both read zero
        apply_stimulus(1, 2'b11, 5'd0, 5'd5, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        idle(1);

        // Plain write then read, and a write to x0 is discarded
        apply_stimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 1, 1, 5'd5, 32'hDEADBEEF, f);
        apply_stimulus(1, 2'b01, 5'd5, 5'd0, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        apply_stimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 1, 1, 5'd0, 32'h1234, f);
        apply_stimulus(1, 2'b11, 5'd0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        idle(1);

        // RAW stall on x7 released by the writeback in the same cycle, with bypass
        apply_stimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd7, 1, 0, 5'd0, 32'h0, f);
        repeat (2) apply_stimulus(1, 2'b10, 5'd0, 5'd7, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        apply_stimulus(1, 2'b10, 5'd0, 5'd7, 0, 5'd0, 1, 1, 5'd7, 32'h55, f);
        idle(1);

        // Back-pressure holds the slot, then refills without an empty cycle
        apply_stimulus(1, 2'b11, 5'd5, 5'd7, 0, 5'd0, 0, 0, 5'd0, 32'h0, f);
        repeat (4) apply_stimulus(1, 2'b01, 5'd7, 5'd0, 0, 5'd0, 0, 0, 5'd0, 32'h0, f);
        apply_stimulus(1, 2'b01, 5'd7, 5'd0, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        idle(1);
        idle(1);

        // WAW stall on x3, then a reservation of x9 colliding with its writeback
        apply_stimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd3, 1, 0, 5'd0, 32'h0, f);
        repeat (2) apply_stimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd3, 1, 0, 5'd0, 32'h0, f);
        apply_stimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 1, 1, 5'd3, 32'h33, f);
        apply_stimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd9, 1, 1, 5'd9, 32'h99, f);
        apply_stimulus(1, 2'b01, 5'd9, 5'd0, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        apply_stimulus(1, 2'b01, 5'd9, 5'd0, 0, 5'd0, 1, 1, 5'd9, 32'hA9, f);
        apply_stimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 1, 1, 5'd10, 32'hA0A0A0A0, f);
        apply_stimulus(1, 2'b11, 5'd10, 5'd3, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        idle(1);

        // Reset while a response is held and x4 is reserved
        apply_stimulus(1, 2'b11, 5'd5, 5'd10, 1, 5'd4, 0, 0, 5'd0, 32'h0, f);
        do_reset();
        apply_stimulus(1, 2'b11, 5'd4, 5'd5, 0, 5'd0, 1, 0, 5'd0, 32'h0, f);
        idle(1);

        // Randomised traffic; writebacks often target a reserved register to keep things moving
        for (int n = 0; n < 600; n++) begin
            wrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0) begin
                start = 5'($urandom_range(0, 31));
                for (int k = 0; k < 32; k++) begin
                    if (m_busy[5'(start + 5'(k))]) begin
                        wrd = 5'(start + 5'(k));
                        break;
                    end
                end
            end
            apply_stimulus(
                1'($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                wrd,
                $urandom(),
                f
            );
        end
        idle(1);
        idle(1);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
